// File: rtl/pc_sequencer.sv
// PC sequencer for the IF stage.
// Owns the fetch PC, the memory request and the branch flush window.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        branch_taken,
  input  logic [31:0] ex_pc,
  input  logic [15:0] imm,
  input  logic        stall,
  input  logic        imem_ack,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic        instr_valid,
  output logic [31:0] instr_pc,
  output logic        flush
);

  typedef enum logic {
    FETCH = 1'b0,
    FLUSH = 1'b1
  } state_t;

  localparam logic [2:0] CNT_LOAD = 3'(FLUSH_CYCLES - 1);

  state_t      state;
  logic [2:0]  cnt;
  logic [31:0] pc;
  logic [31:0] target;
  logic [31:0] offset;
  logic        accept;

  // branch target: word offset relative to the instruction after the branch
  always_comb begin
    offset = {{14{imm[15]}}, imm, 2'b00};
    target = (ex_pc + 32'd4 + offset) & 32'hFFFF_FFFC;
  end

  // request only while fetching, not held, and not in reset
  always_comb begin
    imem_req  = (state == FETCH) && !stall && !reset;
    imem_addr = pc;
    accept    = imem_req && imem_ack;
  end

  // PC, flush window and registered output pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      state       <= FETCH;
      cnt         <= 3'd0;
      instr_valid <= 1'b0;
      instr_pc    <= 32'd0;
      flush       <= 1'b0;
    end else begin
      instr_valid <= 1'b0;
      flush       <= 1'b0;
      if (branch_taken) begin
        pc    <= target;
        flush <= 1'b1;
        cnt   <= CNT_LOAD;
        state <= FLUSH;
      end else begin
        unique case (state)
          FETCH: begin
            if (accept) begin
              instr_valid <= 1'b1;
              instr_pc    <= pc;
              pc          <= pc + 32'd4;
            end
          end
          FLUSH: begin
            if (cnt == 3'd0) begin
              state <= FETCH;
            end else begin
              cnt <= cnt - 3'd1;
            end
          end
          default: state <= FETCH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer.
// Expected fetch PCs are queued at stimulus time and popped on instr_valid.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        branch_taken;
  logic [31:0] ex_pc;
  logic [15:0] imm;
  logic        stall;
  logic        imem_ack;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        instr_valid;
  logic [31:0] instr_pc;
  logic        flush;

  int errors = 0;
  int checks = 0;
  logic [31:0] sb[$];

  pc_sequencer dut (
    .clk(clk),
    .reset(reset),
    .branch_taken(branch_taken),
    .ex_pc(ex_pc),
    .imm(imm),
    .stall(stall),
    .imem_ack(imem_ack),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .instr_valid(instr_valid),
    .instr_pc(instr_pc),
    .flush(flush)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // pop the scoreboard whenever a fetch is reported
  always @(negedge clk) begin
    if (instr_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", instr_pc, 32'hXXXX_XXXX);
      end else begin
        check("instr_pc", instr_pc, sb.pop_front());
      end
    end
  end

  initial begin
    reset = 1'b1;
    branch_taken = 1'b0;
    ex_pc = 32'd0;
    imm = 16'd0;
    stall = 1'b0;
    imem_ack = 1'b1;

    mid();
    check("req_in_reset", 32'(imem_req), 32'd0);
    cyc();
    check("rst_addr", imem_addr, 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_flush", 32'(flush), 32'd0);
    check("rst_ipc", instr_pc, 32'd0);

    reset = 1'b0;
    mid();
    check("req_after_rst", 32'(imem_req), 32'd1);
    for (int i = 0; i < 2; i++) begin
      check("seq_addr", imem_addr, 32'(i * 4));
      sb.push_back(32'(i * 4));
      cyc();
    end

    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mid();
      check("stall_req", 32'(imem_req), 32'd0);
      check("stall_addr", imem_addr, 32'h8);
      cyc();
    end
    stall = 1'b0;
    imem_ack = 1'b0;
    mid();
    check("wait_req", 32'(imem_req), 32'd1);
    cyc();
    check("wait_addr", imem_addr, 32'h8);
    imem_ack = 1'b1;
    sb.push_back(32'h8);
    cyc();
    check("post_stall_addr", imem_addr, 32'hC);

    branch_taken = 1'b1;
    ex_pc = 32'h100;
    imm = 16'h0003;
    cyc();
    check("br_flush", 32'(flush), 32'd1);
    check("br_no_valid", 32'(instr_valid), 32'd0);
    branch_taken = 1'b0;
    mid();
    check("fl1_req", 32'(imem_req), 32'd0);
    cyc();
    check("fl_pulse_end", 32'(flush), 32'd0);
    mid();
    check("fl2_req", 32'(imem_req), 32'd0);
    cyc();
    mid();
    check("tgt_req", 32'(imem_req), 32'd1);
    check("tgt_addr", imem_addr, 32'h110);
    sb.push_back(32'h110);
    cyc();

    imem_ack = 1'b0;
    branch_taken = 1'b1;
    ex_pc = 32'h20;
    imm = 16'hFFFE;
    cyc();
    branch_taken = 1'b0;
    cyc();
    cyc();
    check("neg_addr", imem_addr, 32'h1C);
    imem_ack = 1'b1;
    sb.push_back(32'h1C);
    cyc();

    branch_taken = 1'b1;
    ex_pc = 32'hFFFF_FFF8;
    imm = 16'h0000;
    cyc();
    branch_taken = 1'b0;
    cyc();
    cyc();
    check("wrap_pre", imem_addr, 32'hFFFF_FFFC);
    sb.push_back(32'hFFFF_FFFC);
    cyc();
    imem_ack = 1'b0;
    check("wrap_addr", imem_addr, 32'h0);

    branch_taken = 1'b1;
    ex_pc = 32'h200;
    cyc();
    branch_taken = 1'b0;
    cyc();
    branch_taken = 1'b1;
    ex_pc = 32'h300;
    imm = 16'h0001;
    cyc();
    check("rebr_flush", 32'(flush), 32'd1);
    check("rebr_addr", imem_addr, 32'h308);
    branch_taken = 1'b0;
    mid();
    check("rebr_req1", 32'(imem_req), 32'd0);
    cyc();
    mid();
    check("rebr_req2", 32'(imem_req), 32'd0);
    cyc();
    mid();
    check("rebr_req3", 32'(imem_req), 32'd1);

    cyc();
    branch_taken = 1'b1;
    ex_pc = 32'h400;
    cyc();
    reset = 1'b1;
    imem_ack = 1'b1;
    cyc();
    check("midfl_rst_addr", imem_addr, 32'h0);
    check("midfl_rst_flush", 32'(flush), 32'd0);
    check("midfl_rst_valid", 32'(instr_valid), 32'd0);
    reset = 1'b0;
    branch_taken = 1'b0;
    imem_ack = 1'b0;
    mid();
    check("midfl_rst_req", 32'(imem_req), 32'd1);
    cyc();
    cyc();

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
